// File: rtl/serial_compar.sv
// Bit-serial unsigned magnitude comparator: one MSB-first bit per clock through a
// single eq/gt cascade slice, with registered AeqB/AgtB/AltB results and a done pulse.
module serial_compar #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             AeqB,
  output logic             AgtB,
  output logic             AltB
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             aeqb_q, aeqb_d;
  logic             agtb_q, agtb_d;
  logic             altb_q, altb_d;

  // The single cascade slice, fed by the shift-register MSBs.
  logic a_bit, b_bit, eq_next, gt_next;
  assign a_bit   = a_sh_q[WIDTH-1];
  assign b_bit   = b_sh_q[WIDTH-1];
  assign eq_next = eq_q & ~(a_bit ^ b_bit);
  assign gt_next = gt_q | (eq_q & a_bit & ~b_bit);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cnt_d   = cnt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    aeqb_d  = aeqb_q;
    agtb_d  = agtb_q;
    altb_d  = altb_q;
    case (state_q)
      RUN: begin
        eq_d   = eq_next;
        gt_d   = gt_next;
        a_sh_d = {a_sh_q[WIDTH-2:0], 1'b0};
        b_sh_d = {b_sh_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          // Results are captured on the same edge that enters DONE.
          state_d = DONE;
          aeqb_d  = eq_next;
          agtb_d  = gt_next;
          altb_d  = ~eq_next & ~gt_next;
        end
      end
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = A;
          b_sh_d  = B;
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          cnt_d   = CW'(WIDTH - 1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      aeqb_q  <= 1'b0;
      agtb_q  <= 1'b0;
      altb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      aeqb_q  <= aeqb_d;
      agtb_q  <= agtb_d;
      altb_q  <= altb_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign AeqB = aeqb_q;
  assign AgtB = agtb_q;
  assign AltB = altb_q;

endmodule

// File: tb/tb_serial_compar.sv
// Directed testbench for serial_compar (WIDTH=8): reset, eq/gt/lt results, ignored
// restart, back-to-back comparisons and asynchronous abort.
module tb_serial_compar;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             busy, done, AeqB, AgtB, AltB;

  int checks = 0;
  int errors = 0;

  serial_compar #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .AeqB  (AeqB),
    .AgtB  (AgtB),
    .AltB  (AltB)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, AeqB, AgtB, AltB} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {busy, done, AeqB, AgtB, AltB});
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: got busy/done %b expected 00", {busy, done});
    end
    $display("test_reset: outputs zero in reset and idle after release");
  endtask

  task automatic test_equal();
    A = 8'hA5; B = 8'hA5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      checks++;
      if ({busy, done} !== 2'b10) begin
        errors++;
        $display("FAIL equal_busy[%0d]: got busy/done %b expected 10", i, {busy, done});
      end
      if (i < WIDTH - 1) tick();
    end
    tick();
    checks++;
    if ({busy, done, AeqB, AgtB, AltB} !== 5'b01100) begin
      errors++;
      $display("FAIL equal_result: got %b expected 01100", {busy, done, AeqB, AgtB, AltB});
    end
    $display("test_equal: A=a5 B=a5 AeqB=%0d AgtB=%0d AltB=%0d", AeqB, AgtB, AltB);
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL equal_done_width: got busy/done %b expected 00", {busy, done});
    end
  endtask

  task automatic test_gt_lt();
    A = 8'h80; B = 8'h7F; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < WIDTH; i++) tick();
    checks++;
    if ({done, AeqB, AgtB, AltB} !== 4'b1010) begin
      errors++;
      $display("FAIL gt_result: got %b expected 1010", {done, AeqB, AgtB, AltB});
    end
    $display("test_gt: A=80 B=7f AeqB=%0d AgtB=%0d AltB=%0d", AeqB, AgtB, AltB);
    tick();
    A = 8'h00; B = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    A = 8'hFF; B = 8'h00;
    for (int i = 0; i < WIDTH - 1; i++) tick();
    checks++;
    if ({done, AeqB, AgtB, AltB} !== 4'b0010) begin
      errors++;
      $display("FAIL lt_hold_prev: got %b expected 0010", {done, AeqB, AgtB, AltB});
    end
    tick();
    checks++;
    if ({done, AeqB, AgtB, AltB} !== 4'b1001) begin
      errors++;
      $display("FAIL lt_result: got %b expected 1001", {done, AeqB, AgtB, AltB});
    end
    $display("test_lt: A=00 B=ff AeqB=%0d AgtB=%0d AltB=%0d", AeqB, AgtB, AltB);
    tick();
    tick();
    checks++;
    if ({busy, done, AeqB, AgtB, AltB} !== 5'b00001) begin
      errors++;
      $display("FAIL lt_held: got %b expected 00001", {busy, done, AeqB, AgtB, AltB});
    end
  endtask

  task automatic test_ignore_restart();
    A = 8'h01; B = 8'h02; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    A = 8'hFF; B = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 3; i < WIDTH - 1; i++) begin
      tick();
      checks++;
      if ({busy, done} !== 2'b10) begin
        errors++;
        $display("FAIL ignore_busy[%0d]: got busy/done %b expected 10", i, {busy, done});
      end
    end
    tick();
    checks++;
    if ({done, AeqB, AgtB, AltB} !== 4'b1001) begin
      errors++;
      $display("FAIL ignore_result: got %b expected 1001", {done, AeqB, AgtB, AltB});
    end
    $display("test_ignore_restart: A=01 B=02 AeqB=%0d AgtB=%0d AltB=%0d", AeqB, AgtB, AltB);
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL ignore_return_idle: got busy/done %b expected 00", {busy, done});
    end
  endtask

  task automatic test_back_to_back();
    A = 8'h10; B = 8'h10; start = 1'b1;
    tick();
    for (int i = 1; i < WIDTH; i++) tick();
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_first_busy: got busy/done %b expected 10", {busy, done});
    end
    tick();
    checks++;
    if ({busy, done, AeqB, AgtB, AltB} !== 5'b01100) begin
      errors++;
      $display("FAIL b2b_first_result: got %b expected 01100", {busy, done, AeqB, AgtB, AltB});
    end
    $display("test_back_to_back: A=10 B=10 AeqB=%0d AgtB=%0d AltB=%0d", AeqB, AgtB, AltB);
    A = 8'h11; B = 8'h10;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, done, AeqB} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_restart: got busy/done/AeqB %b expected 101", {busy, done, AeqB});
    end
    for (int i = 1; i < WIDTH; i++) tick();
    tick();
    checks++;
    if ({busy, done, AeqB, AgtB, AltB} !== 5'b01010) begin
      errors++;
      $display("FAIL b2b_second_result: got %b expected 01010", {busy, done, AeqB, AgtB, AltB});
    end
    $display("test_back_to_back: A=11 B=10 AeqB=%0d AgtB=%0d AltB=%0d", AeqB, AgtB, AltB);
    tick();
  endtask

  task automatic test_reset_mid_run();
    int seen_done;
    A = 8'h33; B = 8'h33; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, AeqB, AgtB, AltB} !== 5'b0) begin
      errors++;
      $display("FAIL abort_outputs: got %b expected 00000", {busy, done, AeqB, AgtB, AltB});
    end
    start = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_reset: got busy %b expected 0", busy);
    end
    reset = 1'b0;
    start = 1'b0;
    seen_done = 0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d active cycles expected 0", seen_done);
    end
    A = 8'hFF; B = 8'hFE; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < WIDTH; i++) tick();
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset_latency: got busy/done %b expected 10", {busy, done});
    end
    tick();
    checks++;
    if ({busy, done, AeqB, AgtB, AltB} !== 5'b01010) begin
      errors++;
      $display("FAIL post_reset_result: got %b expected 01010", {busy, done, AeqB, AgtB, AltB});
    end
    $display("test_reset_mid_run: A=ff B=fe AeqB=%0d AgtB=%0d AltB=%0d", AeqB, AgtB, AltB);
  endtask

  initial begin
    test_reset();
    test_equal();
    test_gt_lt();
    test_ignore_restart();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
